// File: rtl/spi_display_receiver.sv
// rtl/spi_display_receiver.sv - display link receiver: deserialiser, command decoder, framebuffer writer
// Oversamples the serial link on clk; data bytes become framebuffer writes inside the active window.
module spi_display_receiver #(
  parameter int COLS       = 128,
  parameter int PAGES      = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  csn,
  input  logic                  dc,
  output logic                  byteValid,
  output logic [7:0]            byteData,
  output logic                  byteIsData,
  output logic                  fbWe,
  output logic [ADDR_WIDTH-1:0] fbAddr,
  output logic [7:0]            fbData,
  output logic                  frameErr
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);
  localparam int AW = (CW > PW) ? CW : PW;
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

  typedef enum logic [2:0] {
    IDLE,
    COL_START,
    COL_END,
    PAGE_START,
    PAGE_END,
    SKIP1
  } stateT;

  logic sclkS1, sclkS2, sclkS3;
  logic mosiS1, mosiS2, mosiS3;
  logic csnS1, csnS2, csnS3;
  logic dcS1, dcS2, dcS3;

  logic [7:0] shiftReg;
  logic [2:0] bitCnt;
  logic       sclkRise, csnRise, bitEdge;
  logic [7:0] shiftNext;

  stateT         stateQ, stateD;
  logic          doWrite, argLoad, colCommit, pageCommit;
  logic [AW-1:0] argTmp;
  logic [CW-1:0] colStart, colEnd, colP, colAdv, curCol;
  logic [PW-1:0] pageStart, pageEnd, pageP, pageAdv, curPage;
  logic          colWrap;

  // Equal-depth synchronisers keep sclk, mosi, csn and dc aligned to the same sample point.
  always_ff @(posedge clk) begin
    if (!reset) begin
      {sclkS1, sclkS2, sclkS3} <= 3'b000;
      {mosiS1, mosiS2, mosiS3} <= 3'b000;
      {csnS1, csnS2, csnS3}    <= 3'b111;
      {dcS1, dcS2, dcS3}       <= 3'b000;
    end else begin
      {sclkS1, sclkS2, sclkS3} <= {sclk, sclkS1, sclkS2};
      {mosiS1, mosiS2, mosiS3} <= {mosi, mosiS1, mosiS2};
      {csnS1, csnS2, csnS3}    <= {csn, csnS1, csnS2};
      {dcS1, dcS2, dcS3}       <= {dc, dcS1, dcS2};
    end
  end

  assign sclkRise  = sclkS2 & ~sclkS3;
  assign csnRise   = csnS2 & ~csnS3;
  assign bitEdge   = sclkRise & ~csnS2;
  assign shiftNext = {shiftReg[6:0], mosiS3};

  always_ff @(posedge clk) begin
    if (!reset) begin
      shiftReg   <= '0;
      bitCnt     <= '0;
      byteValid  <= 1'b0;
      byteData   <= '0;
      byteIsData <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
      if (bitEdge) begin
        shiftReg <= shiftNext;
        if (bitCnt == 3'd7) begin
          byteData   <= shiftNext;
          byteIsData <= dcS3;
          byteValid  <= 1'b1;
          bitCnt     <= '0;
        end else begin
          bitCnt <= bitCnt + 3'd1;
        end
      end else if (csnRise && (bitCnt != 3'd0)) begin
        bitCnt   <= '0;
        frameErr <= 1'b1;
      end
    end
  end

  always_comb begin
    stateD     = stateQ;
    doWrite    = 1'b0;
    argLoad    = 1'b0;
    colCommit  = 1'b0;
    pageCommit = 1'b0;
    if (byteValid) begin
      if (byteIsData) begin
        stateD  = IDLE;
        doWrite = 1'b1;
      end else begin
        case (stateQ)
          IDLE: begin
            case (byteData)
              8'h21: stateD = COL_START;
              8'h22: stateD = PAGE_START;
              8'h81, 8'h8D, 8'hA8, 8'hD3,
              8'hD5, 8'hD9, 8'hDA, 8'hDB: stateD = SKIP1;
              default: stateD = IDLE;
            endcase
          end
          COL_START: begin
            argLoad = 1'b1;
            stateD  = COL_END;
          end
          COL_END: begin
            colCommit = 1'b1;
            stateD    = IDLE;
          end
          PAGE_START: begin
            argLoad = 1'b1;
            stateD  = PAGE_END;
          end
          PAGE_END: begin
            pageCommit = 1'b1;
            stateD     = IDLE;
          end
          SKIP1:   stateD = IDLE;
          default: stateD = IDLE;
        endcase
      end
    end
  end

  // Pointer values after the write currently on fbWe; forwarded so a write in the
  // very next cycle still lands on the advanced address.
  always_comb begin
    colWrap = (colP == colEnd) || (colP == COL_LAST);
    colAdv  = colWrap ? colStart : colP + 1'b1;
    pageAdv = pageP;
    if (colWrap) begin
      pageAdv = ((pageP == pageEnd) || (pageP == PAGE_LAST)) ? pageStart : pageP + 1'b1;
    end
    curCol  = fbWe ? colAdv : colP;
    curPage = fbWe ? pageAdv : pageP;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ    <= IDLE;
      argTmp    <= '0;
      colStart  <= '0;
      colEnd    <= COL_LAST;
      pageStart <= '0;
      pageEnd   <= PAGE_LAST;
      colP      <= '0;
      pageP     <= '0;
      fbWe      <= 1'b0;
      fbAddr    <= '0;
      fbData    <= '0;
    end else begin
      stateQ <= stateD;
      fbWe   <= doWrite;
      if (doWrite) begin
        fbAddr <= ADDR_WIDTH'({curPage, curCol});
        fbData <= byteData;
      end
      if (argLoad) begin
        argTmp <= byteData[AW-1:0];
      end
      // A window commit reloads its pointer and overrides any concurrent advance.
      if (colCommit) begin
        colStart <= argTmp[CW-1:0];
        colEnd   <= byteData[CW-1:0];
        colP     <= argTmp[CW-1:0];
      end else if (fbWe) begin
        colP <= colAdv;
      end
      if (pageCommit) begin
        pageStart <= argTmp[PW-1:0];
        pageEnd   <= byteData[PW-1:0];
        pageP     <= argTmp[PW-1:0];
      end else if (fbWe) begin
        pageP <= pageAdv;
      end
    end
  end

endmodule

// File: tb/tb_spi_display_receiver.sv
// tb/tb_spi_display_receiver.sv - directed bench for spi_display_receiver
module tb_spi_display_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       csn = 1'b1;
  logic       dc = 1'b0;
  logic       byteValid;
  logic [7:0] byteData;
  logic       byteIsData;
  logic       fbWe;
  logic [9:0] fbAddr;
  logic [7:0] fbData;
  logic       frameErr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int riseCyc = 0;
  int bvCyc = 0;
  int weCyc = 0;
  int bvCount = 0;
  int feCount = 0;
  int wrN = 0;
  logic [7:0]  lastByte = 8'h00;
  logic [31:0] isDataLog = '0;
  logic [9:0]  wrAddrLog [0:15];
  logic [7:0]  wrDataLog [0:15];

  spi_display_receiver #(.COLS(128), .PAGES(8), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .csn(csn), .dc(dc),
    .byteValid(byteValid), .byteData(byteData), .byteIsData(byteIsData),
    .fbWe(fbWe), .fbAddr(fbAddr), .fbData(fbData), .frameErr(frameErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byteValid) begin
      bvCount++;
      lastByte  = byteData;
      isDataLog = {isDataLog[30:0], byteIsData};
      bvCyc     = cyc;
    end
    if (fbWe) begin
      if (wrN < 16) begin
        wrAddrLog[wrN] = fbAddr;
        wrDataLog[wrN] = fbData;
      end
      wrN++;
      weCyc = cyc;
    end
    if (frameErr) feCount++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic sendBits(input logic [7:0] b, input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      mosi = b[7-i];
      dc   = d;
      tick(3);
      sclk    = 1'b1;
      riseCyc = cyc;
      tick(3);
    end
    sclk = 1'b0;
    tick(3);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic d);
    sendBits(b, 8, d);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset held with sclk toggling and csn low
    csn  = 1'b0;
    mosi = 1'b1;
    repeat (3) begin
      sclk = ~sclk;
      tick(1);
    end
    chk("rst_byteValid", {31'd0, byteValid}, 32'd0);
    chk("rst_byteData", {24'd0, byteData}, 32'd0);
    chk("rst_byteIsData", {31'd0, byteIsData}, 32'd0);
    chk("rst_fbWe", {31'd0, fbWe}, 32'd0);
    chk("rst_fbAddr", {22'd0, fbAddr}, 32'd0);
    chk("rst_fbData", {24'd0, fbData}, 32'd0);
    chk("rst_frameErr", {31'd0, frameErr}, 32'd0);
    chk("rst_bv_count", bvCount, 0);
    csn  = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(4);

    // column window 16..18, four data bytes wrap onto page 1
    csn = 1'b0;
    tick(3);
    sendByte(8'h21, 1'b0);
    sendByte(8'h10, 1'b0);
    sendByte(8'h12, 1'b0);
    sendByte(8'hAA, 1'b1);
    sendByte(8'hBB, 1'b1);
    sendByte(8'hCC, 1'b1);
    sendByte(8'hDD, 1'b1);
    chk("bv_latency", bvCyc - riseCyc, 3);
    chk("we_latency", weCyc - riseCyc, 4);
    csn = 1'b1;
    tick(4);
    chk("w1_bv_count", bvCount, 7);
    chk("w1_isdata", {25'd0, isDataLog[6:0]}, 32'h0F);
    chk("w1_wr_count", wrN, 4);
    chk("w1_addr0", {22'd0, wrAddrLog[0]}, 16);
    chk("w1_addr1", {22'd0, wrAddrLog[1]}, 17);
    chk("w1_addr2", {22'd0, wrAddrLog[2]}, 18);
    chk("w1_addr3", {22'd0, wrAddrLog[3]}, 144);
    chk("w1_data0", {24'd0, wrDataLog[0]}, 32'hAA);
    chk("w1_data3", {24'd0, wrDataLog[3]}, 32'hDD);

    // single-cell window at the last address
    csn = 1'b0;
    tick(3);
    sendByte(8'h22, 1'b0);
    sendByte(8'h07, 1'b0);
    sendByte(8'h07, 1'b0);
    sendByte(8'h21, 1'b0);
    sendByte(8'h7F, 1'b0);
    sendByte(8'h7F, 1'b0);
    sendByte(8'h11, 1'b1);
    sendByte(8'h22, 1'b1);
    csn = 1'b1;
    tick(4);
    chk("w2_wr_count", wrN, 6);
    chk("w2_addr0", {22'd0, wrAddrLog[4]}, 1023);
    chk("w2_addr1", {22'd0, wrAddrLog[5]}, 1023);
    chk("w2_data0", {24'd0, wrDataLog[4]}, 32'h11);
    chk("w2_data1", {24'd0, wrDataLog[5]}, 32'h22);

    // csn released after 5 bits
    csn = 1'b0;
    tick(3);
    sendBits(8'hF8, 5, 1'b0);
    csn = 1'b1;
    tick(6);
    chk("fe_count", feCount, 1);
    chk("fe_no_byte", bvCount, 15);
    csn = 1'b0;
    tick(3);
    sendByte(8'h5A, 1'b0);
    csn = 1'b1;
    tick(6);
    chk("after_fe_byte", {24'd0, lastByte}, 32'h5A);
    chk("after_fe_count", bvCount, 16);
    chk("after_fe_no_fe", feCount, 1);
    chk("after_fe_no_wr", wrN, 6);

    // aborted column command, default window
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(4);
    csn = 1'b0;
    tick(3);
    sendByte(8'h21, 1'b0);
    sendByte(8'h20, 1'b0);
    sendByte(8'h99, 1'b1);
    sendByte(8'h77, 1'b1);
    chk("abort_wr_count", wrN, 8);
    chk("abort_addr0", {22'd0, wrAddrLog[6]}, 0);
    chk("abort_data0", {24'd0, wrDataLog[6]}, 32'h99);
    chk("abort_addr1", {22'd0, wrAddrLog[7]}, 1);

    // reset in the middle of a byte
    sendBits(8'hA0, 5, 1'b0);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(4);
    chk("midrst_byteData", {24'd0, byteData}, 32'd0);
    chk("midrst_bv", bvCount, 20);
    chk("midrst_fe", feCount, 1);

    // skip-list command swallows 0x21 as its argument
    sendByte(8'h81, 1'b0);
    sendByte(8'h21, 1'b0);
    sendByte(8'h01, 1'b1);
    csn = 1'b1;
    tick(6);
    chk("skip_wr_count", wrN, 9);
    chk("skip_addr", {22'd0, wrAddrLog[8]}, 0);
    chk("skip_data", {24'd0, wrDataLog[8]}, 32'h01);
    chk("final_fe", feCount, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_display_receiver.md
# spi_display_receiver

- Receive-side model of the 4-wire display link our top level drives: serial clock, MOSI, chip select and data/command.
- Deserialises bytes MSB-first and tags each as command or data.
- Decodes the column/page addressing commands, then turns data bytes into framebuffer writes with auto-increment and window wrap.
- Sits on the bench or a second FPGA as the display stand-in, so the transmitter path can be checked byte-for-byte against a framebuffer image.

## Interface
- `COLS`, 128, columns per page; power of two.
- `PAGES`, 8, pages; power of two.
- `ADDR_WIDTH`, 10, framebuffer address width; equals log2(COLS*PAGES).
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `sclk`  in  1  serial clock from link; a bit is sampled on its rising edge.
- `mosi`  in  1  serial data, MSB first.
- `csn`  in  1  chip select, active low.
- `dc`  in  1  0 = command byte, 1 = data byte; sampled with bit 7 (last bit).
- `byteValid`  out  1  one-cycle pulse when a byte completes.
- `byteData`  out  8  completed byte; held until the next completion.
- `byteIsData`  out  1  `dc` captured with that byte.
- `fbWe`  out  1  one-cycle framebuffer write strobe.
- `fbAddr`  out  ADDR_WIDTH  write address = page*COLS + col.
- `fbData`  out  8  write data.
- `frameErr`  out  1  one-cycle pulse: `csn` deasserted with 1–7 bits pending.

## Operation
- Input stage: `sclk`, `mosi`, `csn` and `dc` each pass through a 2-flop synchroniser, then one more flop for edge detect. All four have equal depth, so they stay aligned.
- Bit capture: a synchronised `sclk` rising edge counts only when synchronised `csn` = 0 in the same cycle. On a counted edge, mosi shifts into an 8-bit register and the 3-bit counter increments.
- Byte completion: on the 8th counted edge, load `byteData`, latch `byteIsData` from `dc`, pulse `byteValid`, and clear the counter.
- `csn` rising (synchronised) with counter ≠ 0: discard the partial byte, clear the counter, pulse `frameErr`. With counter = 0 there is no error.
- The decoder state machine, window registers and pointers persist across `csn` toggles.
- Decoder states:
  - IDLE
  - COL_START, COL_END: arguments of 0x21.
  - PAGE_START, PAGE_END: arguments of 0x22.
  - SKIP1: one argument of 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA or 0xDB is discarded.
- Transitions on command bytes:
  - IDLE: 0x21→COL_START, 0x22→PAGE_START, skip-list command→SKIP1. Any other command stays in IDLE and is ignored.
  - Arguments: COL_START→COL_END→IDLE, PAGE_START→PAGE_END→IDLE, SKIP1→IDLE.
  - Argument values are masked to log2(COLS) / log2(PAGES) bits.
- Argument commit: the start/end pair is committed only on the END argument. The committed start value is also loaded into its pointer.
- A data byte arriving in any non-IDLE state aborts the command: partial arguments are discarded, the state goes to IDLE, and the byte is processed as a normal write.
- Data write: `fbWe`=1, `fbAddr`=pageP*COLS+colP, `fbData`=byte.
- Pointer update after each write:
  - If colP == colEnd or colP == COLS-1: colP ← colStart, then advance the page.
  - Otherwise colP+1.
- Page advance: if pageP == pageEnd or pageP == PAGES-1, pageP ← pageStart; otherwise pageP+1.
- Reset values:
  - All outputs 0.
  - Shift register and counter 0; state IDLE.
  - colStart=0, colEnd=COLS-1, pageStart=0, pageEnd=PAGES-1, colP=0, pageP=0.
  - Synchroniser flops: `csn`-path flops reset to 1, all others to 0.

## Timing
- Let edge N be the first `clk` edge at which the pin-side sync flop captures `sclk`=1 for the 8th bit.
  - `byteValid` is high in the cycle after edge N+2.
  - `fbWe` (data byte) is high in the cycle after edge N+3.
  - Pointers are updated at edge N+4.
- `sclk` high and low phases: each ≥1 `clk` period when the source shares `clk`; ≥2 periods when asynchronous.
- `mosi` and `dc` must be stable across the `sclk` rising edge by the same margin.
- Back-to-back bytes are supported with no gap. The minimum byte period is 16 `clk` cycles, and the decoder accepts one byte per cycle.
- Reset mid-byte or mid-command: everything returns to reset values at the next edge, and no `byteValid`, `fbWe` or `frameErr` is issued for the lost byte.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `sclk` toggling → all outputs 0; no `byteValid`.
- Command 0x21, 0x10, 0x12 (dc=0), then data 0xAA, 0xBB, 0xCC, 0xDD → writes to 16, 17, 18, then 144 (col wraps to 16, page 1); `byteIsData` = 0,0,0,1,1,1,1.
- Command 0x22, 0x07, 0x07, then 0x21, 0x7F, 0x7F, then data 0x11, 0x22 → both written at 1023; pointers stay at col 127, page 7.
- Drop `csn` high after 5 bits → one `frameErr` pulse, no `byteValid`. Next full byte 0x5A → `byteData`=0x5A.
- Command 0x21, 0x20 (dc=0), then data 0x99 → command aborted, write 0x99 to 0; a following write goes to 1 (window unchanged).
- Command 0x81, 0x21 (dc=0), then data 0x01 → 0x21 is skipped as an argument, not decoded; write 0x01 to 0.
